// File: rtl/csa_stream_accumulator_if.sv
// Operand-in / sum-out handshake bundle for csa_stream_accumulator.
// master = operand producer and result consumer, slave = the accumulator.
interface csa_stream_accumulator_if #(
    parameter int OP_W  = 5,
    parameter int CNT_W = 5,
    parameter int SUM_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_err
    );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Streaming carry-save accumulator: one 3:2 compression per accepted operand,
// one carry-propagate add per packet. `define CSA_SIGNED_EN for two's-complement operands.
//
// state   | meaning
// ACCUM   | accept operands, compress into sum/carry
// RESOLVE | single cycle: resolve sum+carry into result registers, clear accumulators
// DONE    | result presented until consumer takes it
module csa_stream_accumulator #(
    parameter int OP_W    = 5,
    parameter int MAX_OPS = 16,
    parameter int CNT_W   = 5,
    parameter int SUM_W   = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    csa_stream_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_err_q, out_err_d;
    logic [SUM_W-1:0] op_ext;

`ifdef CSA_SIGNED_EN
    assign op_ext = {{(SUM_W-OP_W){bus.in_data[OP_W-1]}}, bus.in_data};
`else
    assign op_ext = {{(SUM_W-OP_W){1'b0}}, bus.in_data};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_err_d   = out_err_q;

        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    // A full packet drops further operands but still honours in_last.
                    if (cnt_q == MAX_CNT) begin
                        err_d = 1'b1;
                    end else begin
                        sum_d   = op_ext ^ sum_q ^ carry_q;
                        carry_d = ((op_ext & sum_q) | (op_ext & carry_q) | (sum_q & carry_q)) << 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                    if (bus.in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_sum_d   = sum_q + carry_q;
                out_count_d = cnt_q;
                out_err_d   = err_q;
                sum_d       = '0;
                carry_d     = '0;
                cnt_d       = '0;
                err_d       = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: doc/csa_stream_accumulator.md
# csa_stream_accumulator

Sequential multi-operand adder that consumes a stream of narrow operands over a valid/ready handshake. It reduces them in carry-save form and returns one resolved sum per packet on a second valid/ready handshake. It is the receiving end of the operand stream that the three-operand carry-save adder's stimulus side produces. Operands arrive one per cycle rather than all in parallel, and the block generalises the 5-bit / 9-bit carry-save datapath to packets of up to MAX_OPS operands.

## Interface
- OP_W, 5, operand width
- MAX_OPS, 16, maximum operands per packet
- CNT_W, 5, operand-count width; must hold MAX_OPS
- SUM_W, 9, result width; must satisfy SUM_W >= OP_W + ceil(log2(MAX_OPS))

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand present
- in_ready  output  1  block accepts operand this cycle
- in_data  input  OP_W  operand
- in_last  input  1  operand is last of packet
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_sum  output  SUM_W  packet sum, two's-complement/unsigned per configuration
- out_count  output  CNT_W  operands actually summed
- out_err  output  1  packet exceeded MAX_OPS

## Operation
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - RESOLVE: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Internal registers: sum_r, carry_r (SUM_W each), cnt (CNT_W), err (1).
- Operand acceptance (in_valid & in_ready):
  - Operand is extended to SUM_W (see Configuration).
  - One 3:2 compression: sum_r <= a^s^c; carry_r <= ((a&s)|(a&c)|(s&c))<<1, truncated to SUM_W. Here a = extended operand, s = sum_r, c = carry_r.
  - cnt increments.
- Overflow: an operand accepted while cnt==MAX_OPS is discarded (no compression, cnt holds) and err is set.
- in_last on an accepted operand: go to RESOLVE, whether or not that operand was discarded.
- RESOLVE: one cycle.
  - out_sum <= sum_r + carry_r, modulo 2^SUM_W.
  - out_count <= cnt; out_err <= err.
  - sum_r, carry_r, cnt and err clear. Go to DONE.
- DONE: out_sum, out_count and out_err are held stable while out_valid=1. On out_ready, go to ACCUM.
- Empty packets cannot exist: every packet has at least one operand.
- Within SUM_W sizing, arithmetic never wraps for legal packets of MAX_OPS operands or fewer.

## Timing
- Reset (asynchronous, immediate): state=ACCUM; in_ready=1; out_valid=0; out_sum=0; out_count=0; out_err=0; all internal registers 0.
- Throughput: one operand per cycle while in ACCUM.
- Latency:
  - Last operand accepted at edge k.
  - RESOLVE occupies cycle k..k+1.
  - out_valid=1 after edge k+1.
- Result handshake: out_valid & out_ready at edge m gives out_valid=0 and in_ready=1 after edge m. The first operand of the next packet can be accepted at edge m+1.
- Packet rate: minimum packet period is N+2 cycles for an N-operand packet with out_ready held high.
- in_ready is a pure function of state. It has no combinational dependence on in_valid or out_ready.
- in_valid while in_ready=0 is ignored. The upstream side holds the operand.
- Reset mid-packet or mid-DONE: partial sums and any pending result are discarded. No output is produced for that packet.

## Configuration
- CSA_SIGNED_EN defined:
  - Operands and out_sum are two's complement.
  - Operands are sign-extended from bit OP_W-1 to SUM_W.
- CSA_SIGNED_EN undefined:
  - Operands and out_sum are unsigned.
  - Operands are zero-extended.
- No other behaviour changes between the two builds.

## Test plan
- Three-operand packet 5'b11001, 5'b00001, 5'b10010 (last on third), out_ready=1:
  - Unsigned build: out_sum=9'b000101100 (44), out_count=3, out_err=0, valid 2 cycles after last accept.
  - CSA_SIGNED_EN build: out_sum=9'b111101100 (-20).
- Single operand 5'b11111 with in_last: unsigned out_sum=31; signed out_sum=9'h1FF (-1); out_count=1.
- 16 operands of 5'b11111, unsigned, then out_ready held 0 for 5 cycles:
  - out_sum=496 and out_count=16, stable with out_valid=1 throughout.
  - in_ready=0 throughout.
  - Result released on the first out_ready cycle.
- 17 operands of 5'b00001 (last on 17th): out_sum=16, out_count=16, out_err=1. The next packet 5'b00010 gives out_sum=2, out_err=0.
- Back-to-back packets (00011,last) then (00101,last) with in_valid continuously high and out_ready=1: sums 3 then 5. The second operand is accepted exactly 1 cycle after the first result handshake.
- rst_n pulsed low after 2 operands of a packet:
  - All outputs read reset values immediately.
  - A fresh packet 00111,last yields out_sum=7, out_count=1.
